// File: rtl/divider_pkg.sv
// Operation encodings, FSM state type and captured-operand record for the RV32M divider.
// The DIV_OP macros live here too so the core's decoder and this unit share one encoding.
`ifndef DIV_OP_WIDTH
`define DIV_OP_WIDTH 2
`define DIV_OP_DIV   2'b00
`define DIV_OP_DIVU  2'b01
`define DIV_OP_REM   2'b10
`define DIV_OP_REMU  2'b11
`endif

package divider_pkg;

   localparam int DIV_OP_WIDTH = `DIV_OP_WIDTH;

   localparam logic [DIV_OP_WIDTH-1:0] OP_DIV  = `DIV_OP_DIV;
   localparam logic [DIV_OP_WIDTH-1:0] OP_DIVU = `DIV_OP_DIVU;
   localparam logic [DIV_OP_WIDTH-1:0] OP_REM  = `DIV_OP_REM;
   localparam logic [DIV_OP_WIDTH-1:0] OP_REMU = `DIV_OP_REMU;

   typedef enum logic [2:0] {
      IDLE  = 3'b001,
      CALC  = 3'b010,
      READY = 3'b100
   } state_e;

   typedef struct packed {
      logic        is_rem;
      logic        dividend_neg;
      logic        divisor_neg;
      logic        div_by_zero;
      logic [31:0] dividend_raw;
   } div_ctl_t;

   function automatic logic [31:0] neg_if(input logic neg, input logic [31:0] val);
      return neg ? (~val + 32'd1) : val;
   endfunction

endpackage

// File: rtl/divider.sv
// Restoring shift-subtract divider for DIV/DIVU/REM/REMU, one quotient bit per clock.
// ready pulses 34 clocks after valid is sampled; new requests are ignored until back in IDLE with ready low.
module divider
   import divider_pkg::*;
(
   input  logic                    clk,
   input  logic                    reset,
   input  logic [31:0]             dividend,
   input  logic [31:0]             divisor,
   input  logic [DIV_OP_WIDTH-1:0] DIVop,
   input  logic                    valid,
   output logic [31:0]             result,
   output logic                    ready
);

   localparam int IDLE_BIT  = 0;
   localparam int CALC_BIT  = 1;
   localparam int READY_BIT = 2;

   state_e      state;
   state_e      state_nxt;
   div_ctl_t    ctl;
   logic [31:0] divisor_abs;
   logic [31:0] quo_shift;
   logic [31:0] rem;
   logic [32:0] rem_trial;
   logic [4:0]  count;

   logic        start;
   logic        cap_signed;
   logic        cap_dividend_neg;
   logic        cap_divisor_neg;
   logic [31:0] quo_final;
   logic [31:0] rem_final;

   // ready is still high on the first IDLE cycle after READY, which blocks an immediate restart
   assign start = state[IDLE_BIT] & valid & ~ready;

   assign cap_signed       = (DIVop == OP_DIV) || (DIVop == OP_REM);
   assign cap_dividend_neg = cap_signed & dividend[31];
   assign cap_divisor_neg  = cap_signed & divisor[31];

   // quo_shift starts as |dividend| and fills with quotient bits from the right as dividend bits leave
   assign rem_trial = {rem, quo_shift[31]} - {1'b0, divisor_abs};

   assign quo_final = ctl.div_by_zero ? 32'hFFFF_FFFF
                                      : neg_if(ctl.dividend_neg ^ ctl.divisor_neg, quo_shift);
   assign rem_final = ctl.div_by_zero ? ctl.dividend_raw
                                      : neg_if(ctl.dividend_neg, rem);

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = CALC;
         CALC:    if (count == 5'd31) state_nxt = READY;
         READY:   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ready       <= 1'b0;
         result      <= '0;
         count       <= '0;
         ctl         <= '0;
         divisor_abs <= '0;
         quo_shift   <= '0;
         rem         <= '0;
      end else begin
         ready <= 1'b0;
         if (start) begin
            ctl.is_rem       <= (DIVop == OP_REM) || (DIVop == OP_REMU);
            ctl.dividend_neg <= cap_dividend_neg;
            ctl.divisor_neg  <= cap_divisor_neg;
            ctl.div_by_zero  <= (divisor == 32'd0);
            ctl.dividend_raw <= dividend;
            quo_shift        <= neg_if(cap_dividend_neg, dividend);
            divisor_abs      <= neg_if(cap_divisor_neg, divisor);
            rem              <= '0;
            count            <= '0;
         end else if (state[CALC_BIT]) begin
            quo_shift <= {quo_shift[30:0], ~rem_trial[32]};
            rem       <= rem_trial[32] ? {rem[30:0], quo_shift[31]} : rem_trial[31:0];
            count     <= count + 5'd1;
         end else if (state[READY_BIT]) begin
            result <= ctl.is_rem ? rem_final : quo_final;
            ready  <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_divider.sv
// Directed bench for the divider: arithmetic corner cases, handshake timing and mid-operation reset.
module tb_divider;
   import divider_pkg::*;

   logic                    clk;
   logic                    reset;
   logic [31:0]             dividend;
   logic [31:0]             divisor;
   logic [DIV_OP_WIDTH-1:0] DIVop;
   logic                    valid;
   logic [31:0]             result;
   logic                    ready;

   int n_assert;
   int n_fail;
   int cyc;
   int pulses;

   divider dut (
      .clk      (clk),
      .reset    (reset),
      .dividend (dividend),
      .divisor  (divisor),
      .DIVop    (DIVop),
      .valid    (valid),
      .result   (result),
      .ready    (ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_op(input logic [DIV_OP_WIDTH-1:0] op, input logic [31:0] a,
                           input logic [31:0] b);
      DIVop    = op;
      dividend = a;
      divisor  = b;
      valid    = 1'b1;
      tick();
      valid    = 1'b0;
   endtask

   // Counts clock edges from the valid-sampling edge (edge 1) up to the edge that raises ready.
   task automatic wait_ready(input int from_cyc, output int cycles);
      cycles = from_cyc;
      while (!ready && cycles < 80) begin
         tick();
         cycles++;
      end
   endtask

   task automatic run_op(input string tag, input logic [DIV_OP_WIDTH-1:0] op,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
      int c;
      start_op(op, a, b);
      wait_ready(1, c);
      check({tag, "_latency"}, 32'(c), 32'd34);
      check({tag, "_result"}, result, exp);
      tick();
      check({tag, "_ready_drop"}, {31'd0, ready}, 32'd0);
   endtask

   initial begin
      n_assert = 0;
      n_fail   = 0;
      reset    = 1'b1;
      valid    = 1'b0;
      dividend = '0;
      divisor  = '0;
      DIVop    = OP_DIV;
      repeat (3) tick();
      check("reset_ready", {31'd0, ready}, 32'd0);
      check("reset_result", result, 32'd0);
      reset = 1'b0;
      tick();

      run_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd14);
      run_op("remu_100_7", OP_REMU, 32'd100, 32'd7, 32'd2);
      run_op("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
      run_op("rem_m7_2", OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
      run_op("div_7_m2", OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD);
      run_op("rem_7_m2", OP_REM, 32'd7, 32'hFFFF_FFFE, 32'd1);
      run_op("div_min_0", OP_DIV, 32'h8000_0000, 32'd0, 32'hFFFF_FFFF);
      run_op("rem_min_0", OP_REM, 32'h8000_0000, 32'd0, 32'h8000_0000);
      run_op("divu_5_0", OP_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF);
      run_op("remu_5_0", OP_REMU, 32'd5, 32'd0, 32'd5);
      run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
      run_op("rem_ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
      run_op("divu_max_1", OP_DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF);

      // Operands, op and a stray valid pulse change mid-CALC; 1000/7 = 142 must survive.
      start_op(OP_DIVU, 32'd1000, 32'd7);
      repeat (4) tick();
      dividend = 32'd12345;
      divisor  = 32'd3;
      DIVop    = OP_REM;
      valid    = 1'b1;
      tick();
      valid    = 1'b0;
      wait_ready(6, cyc);
      check("midcalc_latency", 32'(cyc), 32'd34);
      check("midcalc_result", result, 32'd142);
      tick();

      // valid held high through the whole op and the ready pulse.
      DIVop    = OP_DIVU;
      dividend = 32'd100;
      divisor  = 32'd7;
      valid    = 1'b1;
      tick();
      wait_ready(1, cyc);
      check("hold_first_latency", 32'(cyc), 32'd34);
      check("hold_first_result", result, 32'd14);
      tick();
      check("hold_ready_drop", {31'd0, ready}, 32'd0);
      dividend = 32'd1000;
      divisor  = 32'd10;
      tick();
      valid = 1'b0;
      wait_ready(1, cyc);
      check("hold_restart_latency", 32'(cyc), 32'd34);
      check("hold_restart_result", result, 32'd100);
      pulses = 0;
      repeat (45) begin
         tick();
         if (ready) pulses++;
      end
      check("hold_no_extra_ready", 32'(pulses), 32'd0);

      // Reset at CALC cycle 10 aborts cleanly.
      start_op(OP_DIVU, 32'd100, 32'd7);
      repeat (9) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("abort_ready", {31'd0, ready}, 32'd0);
      check("abort_result", result, 32'd0);
      pulses = 0;
      repeat (45) begin
         tick();
         if (ready) pulses++;
      end
      check("abort_no_ready", 32'(pulses), 32'd0);
      check("abort_result_held", result, 32'd0);
      run_op("post_reset_divu", OP_DIVU, 32'd1000, 32'd10, 32'd100);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/divider.md
# divider

Multicycle RV32M divide/remainder unit for the kianv multicycle core, the inverse counterpart of the shift-add multiplier. It executes DIV, DIVU, REM and REMU with a restoring shift-subtract algorithm, one quotient bit per clock. It sits beside the multiplier on the ALU side of the datapath and uses the same valid/ready request handshake toward the control unit.

## Interface
- No parameters; data width fixed at 32.
- clk  in  1  core clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- dividend  in  32  rs1 operand.
- divisor  in  32  rs2 operand.
- DIVop  in  `DIV_OP_WIDTH  operation select: `DIV_OP_DIV, `DIV_OP_DIVU, `DIV_OP_REM, `DIV_OP_REMU.
- valid  in  1  request strobe from the control unit.
- result  out  32  quotient (DIV/DIVU) or remainder (REM/REMU).
- ready  out  1  one-cycle completion pulse.

## Operation
- Reset: state=IDLE, ready=0, result=0, iteration counter=0.
- One-hot FSM with states IDLE, CALC, READY.
- IDLE: drive ready=0. If valid=1 and ready=0, capture the following and enter CALC:
  - op and is_signed, where is_signed = DIV or REM;
  - dividend_neg = is_signed & dividend[31], divisor_neg = is_signed & divisor[31];
  - abs values, two's-complement negated when the corresponding neg flag is set;
  - div_by_zero = (divisor == 0).
  - Also clear the quotient and 33-bit partial remainder, and set count=0.
- CALC, each cycle:
  - rem_trial = {rem[31:0], quo_shift[31]} − {1'b0, divisor_abs};
  - if rem_trial is non-negative, rem ← rem_trial and the shifted-in quotient bit = 1; otherwise keep the shifted remainder and shift in 0;
  - count increments. After the count=31 iteration, go to READY.
- READY: compute the signed result into result, set ready=1, return to IDLE.
  - Quotient is negated iff dividend_neg XOR divisor_neg.
  - Remainder is negated iff dividend_neg.
- Special cases override in READY:
  - Divide by zero: quotient = 0xFFFFFFFF for both DIV and DIVU; remainder = original dividend.
  - Signed overflow, 0x80000000 / 0xFFFFFFFF: quotient = 0x80000000, remainder = 0. The normal path yields this; no override is needed, but it must be verified.
- Operands and op are latched at start. Inputs may change during CALC without effect.
- result holds its value until the next READY state. It is not cleared on a new start.

## Timing
- Start edge S: valid=1 is sampled in IDLE.
- CALC occupies edges S+1 through S+32.
- READY is edge S+33, and ready is high in the cycle following S+33.
- ready falls at edge S+34.
- Latency from the valid sample to ready high is 34 cycles; throughput is one op per 35 cycles minimum.
- If valid is still high while ready=1, no restart occurs (guarded by !ready). If valid is still high in the next cycle, a new operation starts. The control unit must drop valid on ready.
- Synchronous reset asserted in any state, including mid-CALC, aborts the operation next edge:
  - ready=0, result=0, state=IDLE;
  - no spurious ready pulse.
- valid is ignored while in CALC or READY.

## Structure
- Add `DIV_OP_WIDTH and the four `DIV_OP_* encodings to riscv_defines.vh, alongside the MUL_OP defines.
- State bit indices are local constants.
- Single module with no sub-module; the subtract/compare step is inline combinational logic.
- Estimated size: roughly 150–200 lines.

## Test plan
- DIVU 100/7 -> result 14; REMU 100/7 -> 2; ready exactly 34 cycles after the valid sample, high for 1 cycle.
- DIV 0xFFFFFFF9 (−7) / 2 -> 0xFFFFFFFD (−3); REM -> 0xFFFFFFFF (−1); DIV 7 / 0xFFFFFFFE -> 0xFFFFFFFD; REM -> 1.
- Divide by zero:
  - DIV 0x80000000/0 -> 0xFFFFFFFF and REM -> 0x80000000;
  - DIVU 5/0 -> 0xFFFFFFFF and REMU -> 5.
- Overflow: DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM -> 0. DIVU 0xFFFFFFFF/1 -> 0xFFFFFFFF.
- Handshake: change dividend/divisor mid-CALC -> result unaffected. Hold valid high through ready -> exactly one restart, beginning the cycle after ready falls.
- Reset: assert reset at CALC cycle 10 -> ready stays 0 and result = 0. Then DIVU 1000/10 -> 100, with correct 34-cycle latency.
